// File: rtl/serial_bus_arbiter.sv
// Round-robin bus arbiter: level requests, registered one-hot grant held for
// the whole tenure, and a watchdog that evicts and locks out stalled masters.
module serial_bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int IDX_W     = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 xfer_done,
    output logic [N_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 bus_busy,
    output logic                 timeout,
    output logic [1:0]           dbg_state_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [7:0]       TMO_LIMIT = 8'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_MASTERS - 1);

    logic [1:0]           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [N_MASTERS-1:0] lock_q, lock_d;

    logic [N_MASTERS-1:0] elig;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     cand_idx;

    // Candidate index at a given distance above the round-robin pointer, wrapped.
    function automatic logic [IDX_W-1:0] rr_cand(input logic [IDX_W-1:0] base, input int off);
        int p;
        p = int'(base) + off;
        if (p >= N_MASTERS) p = p - N_MASTERS;
        return IDX_W'(p);
    endfunction

    always_comb begin
        elig      = req & ~lock_q;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            cand_idx = rr_cand(rr_q, k);
            if (!sel_found && elig[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        // A master that lets go of its request is forgiven immediately.
        lock_d    = lock_q & req;

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    grant_d = N_MASTERS'(1) << sel_idx;
                    idx_d   = sel_idx;
                    busy_d  = 1'b1;
                    rr_d    = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!req[idx_q]) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    state_d = S_RELEASE;
                end else if (xfer_done) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == TMO_LIMIT) begin
                    grant_d       = '0;
                    busy_d        = 1'b0;
                    timeout_d     = 1'b1;
                    lock_d[idx_q] = 1'b1;
                    state_d       = S_RELEASE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= 8'd0;
            rr_q      <= '0;
            lock_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            lock_q    <= lock_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign bus_busy    = busy_q;
    assign timeout     = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter with four masters and a short watchdog.
module tb_serial_bus_arbiter;
    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int TMO = 4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic          xfer_done;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          bus_busy;
    logic          timeout;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    serial_bus_arbiter #(.N_MASTERS(N), .IDX_W(IW), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .xfer_done   (xfer_done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .bus_busy    (bus_busy),
        .timeout     (timeout),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Packs grant, grant_idx, bus_busy, timeout into one comparison.
    task automatic check_bus(input string tag, input logic [3:0] g, input logic [1:0] i,
                             input logic b, input logic t);
        check(tag, {24'd0, grant, grant_idx, bus_busy, timeout}, {24'd0, g, i, b, t});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req = '0;
        xfer_done = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    task automatic wait_grant(input string tag, output int gap);
        gap = 0;
        while (!bus_busy && gap < 12) begin
            step(1);
            gap++;
        end
        check(tag, {31'd0, bus_busy}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end expected end");
        $fatal(1);
    end

    initial begin
        int gap;
        int e;

        // Reset state and single master
        reset = 1'b0; req = '0; xfer_done = 1'b0;
        step(2);
        check_bus("por_outputs", 4'b0000, 2'd0, 1'b0, 1'b0);
        check("por_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        reset = 1'b1;
        req = 4'b0001;
        step(1);
        check_bus("single_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        check("single_state", {30'd0, dbg_state}, {30'd0, S_BUSY});
        step(1);
        #3 reset = 1'b0; req = '0;
        #1;
        check_bus("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        check("async_reset_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        #1 reset = 1'b1; req = 4'b0001;
        step(1);
        check_bus("post_reset_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1);
        req = 4'b0000;
        step(1);
        check_bus("single_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        check("single_drop_state", {30'd0, dbg_state}, {30'd0, S_RELEASE});
        req = 4'b0001;
        step(1);
        check("dead_cycle2", {28'd0, grant}, 32'd0);
        check("dead_cycle2_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        step(1);
        check_bus("regrant_after_gap", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        step(2);

        // Round robin with all four requesting
        do_reset();
        exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_grant("rr_arrive", gap);
            e = int'(exp_q.pop_front());
            check("rr_idx", {30'd0, grant_idx}, e);
            check("rr_onehot", {28'd0, grant}, 32'd1 << e);
            if (t > 0) check("rr_gap", gap, 2);
            step(2);
            req[e] = 1'b0;
            step(1);
            check("rr_drop", {28'd0, grant}, 32'd0);
            req[e] = 1'b1;
        end
        req = 4'b0000;
        step(3);

        // Pointer fairness
        do_reset();
        req = 4'b0100;
        step(1);
        check_bus("fair_first", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        step(1);
        check("fair_release", {28'd0, grant}, 32'd0);
        req = 4'b0101;
        step(2);
        check_bus("fair_wrap_to_0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0100;
        step(1);
        check_bus("fair_idx_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0101;
        step(2);
        check_bus("fair_next_2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        step(3);

        // Watchdog eviction and lockout
        do_reset();
        req = 4'b0010;
        step(1);
        check_bus("tmo_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        for (int i = 1; i <= TMO; i++) begin
            step(1);
            check_bus("tmo_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step(1);
        check_bus("tmo_fire", 4'b0000, 2'd1, 1'b0, 1'b1);
        check("tmo_fire_state", {30'd0, dbg_state}, {30'd0, S_RELEASE});
        step(1);
        check_bus("tmo_pulse_end", 4'b0000, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("tmo_locked", {28'd0, grant}, 32'd0);
        end
        req = 4'b0011;
        step(1);
        check_bus("tmo_other_served", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("tmo_still_locked", {28'd0, grant}, 32'd0);
        end
        req = 4'b0000;
        step(1);
        req = 4'b0010;
        step(1);
        check_bus("tmo_unlocked", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        step(3);

        // Watchdog refreshed by transfers
        do_reset();
        req = 4'b0001;
        step(1);
        check_bus("wd_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            xfer_done = (i % 3 == 2);
            step(1);
            check("wd_hold", {27'd0, grant, timeout}, {27'd0, 4'b0001, 1'b0});
        end
        xfer_done = 1'b0;
        req = 4'b0000;
        step(3);

        // Release coinciding with watchdog expiry
        do_reset();
        req = 4'b1000;
        step(1);
        check_bus("sim_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        step(TMO);
        req = 4'b0000;
        step(1);
        check_bus("sim_drop_at_limit", 4'b0000, 2'd3, 1'b0, 1'b0);
        req = 4'b1000;
        step(2);
        check_bus("sim_no_lockout", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Release coinciding with a transfer pulse
        step(1);
        req = 4'b0000;
        xfer_done = 1'b1;
        step(1);
        xfer_done = 1'b0;
        check_bus("sim_drop_with_xfer", 4'b0000, 2'd3, 1'b0, 1'b0);
        check("sim_drop_with_xfer_state", {30'd0, dbg_state}, {30'd0, S_RELEASE});
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
